// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the iterative divider: FSM states, iteration
// count, divide-by-zero constant and an operand magnitude helper.
package div_unit_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIN} div_state_t;

   localparam int unsigned DIV_ITERS = 32;

   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

   // Magnitude of a 32-bit operand; unsigned ops pass through unchanged.
   // abs(0x80000000) wraps back to 0x80000000, which is the right
   // unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Start/busy/done handshake between EX-stage control and the divider.
interface div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output start, signed_op, dividend, divisor, cancel,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, signed_op, dividend, divisor, cancel,
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the 64-bit
// {partial remainder, quotient} working register.
module div_step (
   input  logic [63:0] work,
   input  logic [31:0] divisor,
   output logic [63:0] work_next
);

   logic        ge;
   logic [31:0] diff;

   // Shift left, trial-subtract from the upper 33 bits, keep if non-negative.
   // When the trial succeeds the true difference is below 2^32, so the
   // modulo-2^32 subtraction of the low 32 bits is exact.
   always_comb begin
      ge   = (work[63:31] >= {1'b0, divisor});
      diff = work[62:31] - divisor;
      if (ge) begin
         work_next = {diff, work[30:0], 1'b1};
      end else begin
         work_next = {work[62:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit for the EX stage: quotient to LO,
// remainder to HI, 34-cycle latency, cancellable by pipeline flush.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   div_unit_if.slave bus
);

   div_state_t         state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] work_q, work_d, work_step;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic [WIDTH-1:0]   orig_q, orig_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               launch;

   div_step u_step (
      .work      (work_q),
      .divisor   (dvsr_q),
      .work_next (work_step)
   );

   // Next-state, operand capture, iteration and result writeback.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      dvsr_d  = dvsr_q;
      orig_d  = orig_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      launch  = bus.start & ~bus.cancel;

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               work_d  = {{WIDTH{1'b0}}, abs32(bus.dividend, bus.signed_op)};
               dvsr_d  = abs32(bus.divisor, bus.signed_op);
               orig_d  = bus.dividend;
               q_neg_d = bus.signed_op & (bus.dividend[31] ^ bus.divisor[31]);
               r_neg_d = bus.signed_op & bus.dividend[31];
               dz_d    = (bus.divisor == '0);
               cnt_d   = '0;
               state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
               if (bus.divisor == '0) begin
                  state_d = FIN;
               end
`endif
            end
         end
         CALC: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else begin
               work_d = work_step;
               cnt_d  = cnt_q + 5'd1;  // wraps 31 -> 0 on the way to FIN
               if (cnt_q == 5'(DIV_ITERS - 1)) begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            if (!bus.cancel) begin
               done_d = 1'b1;
               if (dz_q) begin
                  quot_d = DIV_ZERO_QUOT;
                  rem_d  = orig_q;
               end else begin
                  quot_d = q_neg_q ? (~work_q[WIDTH-1:0] + 1'b1) : work_q[WIDTH-1:0];
                  rem_d  = r_neg_q ? (~work_q[2*WIDTH-1:WIDTH] + 1'b1)
                                   : work_q[2*WIDTH-1:WIDTH];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         dvsr_q  <= '0;
         orig_q  <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         dvsr_q  <= dvsr_d;
         orig_q  <= orig_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;

endmodule
